// File: rtl/kv_pkg.sv
// Shared types and constants for the line-fetch arbiter.
// Port indices, FSM encoding and the default line geometry.
package kv_pkg;

  localparam int KV_DATA_WIDTH = 32;
  localparam int KV_ADDR_WIDTH = 32;
  localparam int KV_LINE_SIZE  = 4;
  localparam int KV_NPORTS     = 2;

  localparam logic KV_PORT_ICACHE = 1'b0;
  localparam logic KV_PORT_DCACHE = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_DATA,
    RESPOND
  } kv_arb_state_t;

  typedef logic [KV_LINE_SIZE-1:0][KV_DATA_WIDTH-1:0] kv_line_t;

  function automatic logic kv_other(input logic id);
    return ~id;
  endfunction

endpackage

// File: rtl/kv_rr_arbiter2.sv
// Two-way round-robin pick between I-cache and D-cache requests.
// prio names the port that wins when both are valid.
module kv_rr_arbiter2
  import kv_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       prio,
  output logic [1:0] grant,
  output logic       grant_id
);

  always_comb begin
    grant    = '0;
    grant_id = prio;
    unique case (1'b1)
      (valid == 2'b11): grant_id = prio;
      (valid == 2'b01): grant_id = KV_PORT_ICACHE;
      (valid == 2'b10): grant_id = KV_PORT_DCACHE;
      default:          grant_id = prio;
    endcase
    grant[grant_id] = |valid;
  end

endmodule

// File: rtl/kv_mem_fetch_arbiter.sv
// Shares one memory line-fetch port between the I-cache and D-cache.
// One transaction in flight: IDLE -> ISSUE -> WAIT_DATA -> RESPOND.
module kv_mem_fetch_arbiter
  import kv_pkg::*;
#(
  parameter int DATA_WIDTH = KV_DATA_WIDTH,
  parameter int ADDR_WIDTH = KV_ADDR_WIDTH,
  parameter int LINE_SIZE  = KV_LINE_SIZE
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [ADDR_WIDTH-1:0] i_req_addr [KV_NPORTS],
  input  logic                  i_req_valid [KV_NPORTS],
  output logic                  o_req_ready [KV_NPORTS],
  output logic [DATA_WIDTH-1:0] o_resp_data [LINE_SIZE],
  output logic                  o_resp_valid [KV_NPORTS],
  input  logic                  i_resp_ready [KV_NPORTS],
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic                  o_mem_addr_valid,
  input  logic                  i_mem_addr_ready,
  input  logic [DATA_WIDTH-1:0] i_mem_data [LINE_SIZE],
  input  logic                  i_mem_data_valid,
  output logic                  o_mem_data_ready
);

  kv_arb_state_t         state;
  logic                  grant_id;
  logic                  prio;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] line_q [LINE_SIZE];
  logic [1:0]            req_vld;
  logic [1:0]            resp_vld;
  logic [1:0]            pick;
  logic                  pick_id;
  logic                  mem_addr_vld;
  logic                  mem_data_rdy;
  logic                  idle_ok;

  assign req_vld = {i_req_valid[1], i_req_valid[0]};

  kv_rr_arbiter2 u_arb (
    .valid    (req_vld),
    .prio     (prio),
    .grant    (pick),
    .grant_id (pick_id)
  );

  // Ready is combinational; mask it during reset so every output is 0.
  assign idle_ok = (state == IDLE) && !i_rst;

  always_comb begin
    for (int i = 0; i < KV_NPORTS; i++) begin
      o_req_ready[i]  = idle_ok & pick[i];
      o_resp_valid[i] = resp_vld[i];
    end
    for (int w = 0; w < LINE_SIZE; w++) begin
      o_resp_data[w] = line_q[w];
    end
  end

  assign o_mem_addr       = addr_q;
  assign o_mem_addr_valid = mem_addr_vld;
  assign o_mem_data_ready = mem_data_rdy;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state        <= IDLE;
      prio         <= KV_PORT_ICACHE;
      grant_id     <= KV_PORT_ICACHE;
      addr_q       <= '0;
      mem_addr_vld <= 1'b0;
      mem_data_rdy <= 1'b0;
      resp_vld     <= '0;
      for (int w = 0; w < LINE_SIZE; w++) begin
        line_q[w] <= '0;
      end
    end else begin
      unique case (state)
        IDLE: begin
          if (|req_vld) begin
            addr_q       <= i_req_addr[pick_id];
            grant_id     <= pick_id;
            mem_addr_vld <= 1'b1;
            state        <= ISSUE;
          end
        end
        ISSUE: begin
          if (i_mem_addr_ready) begin
            mem_addr_vld <= 1'b0;
            mem_data_rdy <= 1'b1;
            state        <= WAIT_DATA;
          end
        end
        WAIT_DATA: begin
          if (i_mem_data_valid) begin
            for (int w = 0; w < LINE_SIZE; w++) begin
              line_q[w] <= i_mem_data[w];
            end
            mem_data_rdy       <= 1'b0;
            resp_vld[grant_id] <= 1'b1;
            state              <= RESPOND;
          end
        end
        RESPOND: begin
          // The port just served yields the next tie.
          if (i_resp_ready[grant_id]) begin
            resp_vld <= '0;
            prio     <= kv_other(grant_id);
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_kv_mem_fetch_arbiter.sv
// Directed bench for kv_mem_fetch_arbiter: transaction table plus
// hand sequences for reset, spurious inputs and mid-flight reset.
module tb_kv_mem_fetch_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] req_addr [2];
  logic        req_valid [2];
  logic        req_ready [2];
  logic [31:0] resp_data [4];
  logic        resp_valid [2];
  logic        resp_ready [2];
  logic [31:0] mem_addr;
  logic        mem_addr_valid;
  logic        mem_addr_ready;
  logic [31:0] mem_data [4];
  logic        mem_data_valid;
  logic        mem_data_ready;

  always #5 clk = ~clk;

  kv_mem_fetch_arbiter dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_req_addr       (req_addr),
    .i_req_valid      (req_valid),
    .o_req_ready      (req_ready),
    .o_resp_data      (resp_data),
    .o_resp_valid     (resp_valid),
    .i_resp_ready     (resp_ready),
    .o_mem_addr       (mem_addr),
    .o_mem_addr_valid (mem_addr_valid),
    .i_mem_addr_ready (mem_addr_ready),
    .i_mem_data       (mem_data),
    .i_mem_data_valid (mem_data_valid),
    .o_mem_data_ready (mem_data_ready)
  );

  typedef struct {
    bit               pre_rst;
    bit               v0;
    bit               v1;
    logic [31:0]      a0;
    logic [31:0]      a1;
    logic [3:0][31:0] data;
    int               aw;
    int               dw;
    int               rw;
    int               port;
    logic [31:0]      ea;
  } vec_t;

  vec_t vecs [9];
  int   n_chk  = 0;
  int   n_fail = 0;

  function automatic vec_t mk(bit pr, bit v0, bit v1,
                              logic [31:0] a0, logic [31:0] a1,
                              logic [31:0] w0, logic [31:0] w1,
                              logic [31:0] w2, logic [31:0] w3,
                              int aw, int dw, int rw,
                              int port, logic [31:0] ea);
    vec_t v;
    v.pre_rst = pr;
    v.v0 = v0;
    v.v1 = v1;
    v.a0 = a0;
    v.a1 = a1;
    v.data = {w3, w2, w1, w0};
    v.aw = aw;
    v.dw = dw;
    v.rw = rw;
    v.port = port;
    v.ea = ea;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet(string tag);
    chk({tag, "_req_ready0"}, 32'(req_ready[0]), 0);
    chk({tag, "_req_ready1"}, 32'(req_ready[1]), 0);
    chk({tag, "_resp_valid0"}, 32'(resp_valid[0]), 0);
    chk({tag, "_resp_valid1"}, 32'(resp_valid[1]), 0);
    chk({tag, "_mem_addr_valid"}, 32'(mem_addr_valid), 0);
    chk({tag, "_mem_data_ready"}, 32'(mem_data_ready), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    chk_quiet("rst");
    chk("rst_mem_addr", mem_addr, 0);
    for (int w = 0; w < 4; w++) chk("rst_resp_data", resp_data[w], 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic run_txn(input vec_t v);
    int p;
    int q;
    p = v.port;
    q = 1 - v.port;
    if (v.pre_rst) do_reset();
    req_valid[0] = v.v0;
    req_valid[1] = v.v1;
    req_addr[0] = v.a0;
    req_addr[1] = v.a1;
    mem_addr_ready = 1'b0;
    mem_data_valid = 1'b0;
    resp_ready[0] = 1'b0;
    resp_ready[1] = 1'b0;
    @(negedge clk);
    chk("acc_ready_win", 32'(req_ready[p]), 1);
    chk("acc_ready_lose", 32'(req_ready[q]), 0);
    chk("idle_mem_addr_valid", 32'(mem_addr_valid), 0);
    chk("idle_resp_valid0", 32'(resp_valid[0]), 0);
    chk("idle_resp_valid1", 32'(resp_valid[1]), 0);
    tick();
    req_valid[p] = 1'b0;
    for (int k = 0; k <= v.aw; k++) begin
      mem_addr_ready = (k == v.aw);
      @(negedge clk);
      chk("iss_addr_valid", 32'(mem_addr_valid), 1);
      chk("iss_addr", mem_addr, v.ea);
      chk("iss_data_ready", 32'(mem_data_ready), 0);
      chk("iss_no_accept0", 32'(req_ready[0]), 0);
      chk("iss_no_accept1", 32'(req_ready[1]), 0);
      tick();
    end
    mem_addr_ready = 1'b0;
    for (int k = 0; k <= v.dw; k++) begin
      mem_data_valid = (k == v.dw);
      for (int w = 0; w < 4; w++)
        mem_data[w] = (k == v.dw) ? v.data[w] : 32'hDEAD_0000 + 32'(k);
      @(negedge clk);
      chk("wd_data_ready", 32'(mem_data_ready), 1);
      chk("wd_addr_valid", 32'(mem_addr_valid), 0);
      chk("wd_resp_valid", 32'(resp_valid[p]), 0);
      chk("wd_no_accept0", 32'(req_ready[0]), 0);
      chk("wd_no_accept1", 32'(req_ready[1]), 0);
      tick();
    end
    mem_data_valid = 1'b0;
    for (int w = 0; w < 4; w++) mem_data[w] = 32'hBAD0_0000 + 32'(w);
    for (int k = 0; k <= v.rw; k++) begin
      resp_ready[p] = (k == v.rw);
      resp_ready[q] = 1'b1;
      @(negedge clk);
      chk("rsp_valid_win", 32'(resp_valid[p]), 1);
      chk("rsp_valid_other", 32'(resp_valid[q]), 0);
      for (int w = 0; w < 4; w++) chk("rsp_data", resp_data[w], v.data[w]);
      chk("rsp_data_ready", 32'(mem_data_ready), 0);
      chk("rsp_no_accept0", 32'(req_ready[0]), 0);
      chk("rsp_no_accept1", 32'(req_ready[1]), 0);
      tick();
    end
    resp_ready[0] = 1'b0;
    resp_ready[1] = 1'b0;
  endtask

  initial begin
    vecs[0] = mk(0, 1, 0, 32'h1111_1000, 32'h0,
                 32'd1, 32'd2, 32'd3, 32'd4, 0, 0, 0, 0, 32'h1111_1000);
    vecs[1] = mk(1, 1, 1, 32'h0000_0040, 32'h0000_0080,
                 32'hA000_0001, 32'hA000_0002, 32'hA000_0003, 32'hA000_0004,
                 0, 0, 0, 0, 32'h0000_0040);
    vecs[2] = mk(0, 0, 1, 32'h0, 32'h0000_0080,
                 32'hB000_0001, 32'hB000_0002, 32'hB000_0003, 32'hB000_0004,
                 0, 0, 0, 1, 32'h0000_0080);
    vecs[3] = mk(0, 1, 1, 32'h0000_0100, 32'h0000_0200,
                 32'hC000_0001, 32'hC000_0002, 32'hC000_0003, 32'hC000_0004,
                 0, 1, 0, 0, 32'h0000_0100);
    vecs[4] = mk(0, 0, 1, 32'h0, 32'h0000_0200,
                 32'hD1D2_D3D4, 32'h0F0F_0F0F, 32'hFFFF_FFFF, 32'h8000_0001,
                 5, 7, 0, 1, 32'h0000_0200);
    vecs[5] = mk(0, 1, 0, 32'h0000_0500, 32'h0,
                 32'hE000_0001, 32'hE000_0002, 32'hE000_0003, 32'hE000_0004,
                 0, 0, 2, 0, 32'h0000_0500);
    vecs[6] = mk(0, 1, 1, 32'h0000_0600, 32'h0000_0700,
                 32'hF000_0001, 32'hF000_0002, 32'hF000_0003, 32'hF000_0004,
                 0, 0, 6, 1, 32'h0000_0700);
    vecs[7] = mk(0, 1, 0, 32'h0000_0600, 32'h0,
                 32'h9000_0001, 32'h9000_0002, 32'h9000_0003, 32'h9000_0004,
                 0, 0, 0, 0, 32'h0000_0600);
    vecs[8] = mk(0, 1, 1, 32'h0000_0400, 32'h0000_0480,
                 32'h7000_0001, 32'h7000_0002, 32'h7000_0003, 32'h7000_0004,
                 0, 0, 0, 0, 32'h0000_0400);

    rst = 1'b1;
    req_addr[0] = 32'h0000_1234;
    req_addr[1] = 32'h0000_5678;
    req_valid[0] = 1'b1;
    req_valid[1] = 1'b1;
    resp_ready[0] = 1'b0;
    resp_ready[1] = 1'b0;
    mem_addr_ready = 1'b0;
    mem_data_valid = 1'b0;
    for (int w = 0; w < 4; w++) mem_data[w] = 32'h0;
    #1;
    do_reset();

    req_valid[0] = 1'b0;
    req_valid[1] = 1'b0;
    mem_data_valid = 1'b1;
    resp_ready[0] = 1'b1;
    resp_ready[1] = 1'b1;
    for (int w = 0; w < 4; w++) mem_data[w] = 32'h5555_0000 + 32'(w);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk_quiet("spur");
      tick();
    end
    chk("spur_buffer", resp_data[0], 0);
    mem_data_valid = 1'b0;
    resp_ready[0] = 1'b0;
    resp_ready[1] = 1'b0;

    for (int i = 0; i < 8; i++) run_txn(vecs[i]);

    req_valid[0] = 1'b0;
    req_valid[1] = 1'b1;
    req_addr[1] = 32'h0000_0300;
    mem_addr_ready = 1'b1;
    @(negedge clk);
    chk("mr_accept", 32'(req_ready[1]), 1);
    tick();
    req_valid[1] = 1'b0;
    tick();
    mem_addr_ready = 1'b0;
    @(negedge clk);
    chk("mr_wait_data", 32'(mem_data_ready), 1);
    #2;
    rst = 1'b1;
    mem_data_valid = 1'b1;
    for (int w = 0; w < 4; w++) mem_data[w] = 32'h3333_0000 + 32'(w);
    #1;
    chk_quiet("mr_async");
    chk("mr_mem_addr", mem_addr, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    mem_data_valid = 1'b0;
    run_txn(vecs[8]);

    req_valid[0] = 1'b0;
    req_valid[1] = 1'b0;
    @(negedge clk);
    chk_quiet("final_idle");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/kv_mem_fetch_arbiter.md
# kv_mem_fetch_arbiter

Shares the single memory read (line-fetch) port between two cache requesters: port 0 is the instruction cache, port 1 is the data cache. Each requester presents a line-fetch address with a valid/ready handshake and receives a full `LINE_SIZE`-word line back with a valid/ready handshake. The block sits between the two caches' fetch interfaces and the memory read interface. It keeps one transaction in flight and grants round-robin between the two ports.

## Interface
- `DATA_WIDTH`, 32, word width
- `ADDR_WIDTH`, 32, address width
- `LINE_SIZE`, 4, words per line transferred
- `i_clk`  in  1  clock, rising edge
- `i_rst`  in  1  reset; asynchronous, active-high
- `i_req_addr[2]`  in  ADDR_WIDTH each  requester line address; index 0 = I-cache, 1 = D-cache
- `i_req_valid[2]`  in  1 each  request valid
- `o_req_ready[2]`  out  1 each  request accepted this cycle
- `o_resp_data[LINE_SIZE]`  out  DATA_WIDTH each  returned line, shared by both ports
- `o_resp_valid[2]`  out  1 each  line valid for that port
- `i_resp_ready[2]`  in  1 each  requester takes line
- `o_mem_addr`  out  ADDR_WIDTH  address to memory
- `o_mem_addr_valid`  out  1  address valid
- `i_mem_addr_ready`  in  1  memory accepts address
- `i_mem_data[LINE_SIZE]`  in  DATA_WIDTH each  line from memory
- `i_mem_data_valid`  in  1  line valid
- `o_mem_data_ready`  out  1  arbiter takes line

## Operation
- States:
  - IDLE → ISSUE → WAIT_DATA → RESPOND → IDLE.
  - Registers: `grant_id` (1 bit), `prio` (1 bit, port that wins a tie), `addr_q`, line buffer `LINE_SIZE × DATA_WIDTH`.
- IDLE:
  - Winner: the only valid port, or `prio` if both are valid.
  - `o_req_ready[winner]`=1, combinational from `i_req_valid`; the other port's ready is 0.
  - On valid&ready: latch `addr_q` and `grant_id`, go to ISSUE.
  - No valid: stay in IDLE, all readies 0.
- ISSUE:
  - `o_mem_addr_valid`=1, `o_mem_addr`=`addr_q`, both held stable.
  - On `i_mem_addr_ready`: go to WAIT_DATA.
- WAIT_DATA:
  - `o_mem_data_ready`=1.
  - On `i_mem_data_valid`: capture all `LINE_SIZE` words into the buffer, go to RESPOND.
- RESPOND:
  - `o_resp_valid[grant_id]`=1 and `o_resp_data`=buffer, both held stable.
  - On `i_resp_ready[grant_id]`: set `prio` ← ~`grant_id`, go to IDLE.
- Address handling:
  - Forwarded unmodified; line alignment is the cache's job.
  - No width conversion; data words pass bit-exact.
- Inputs outside the active state are ignored: `i_mem_data_valid` in IDLE/ISSUE, and `i_resp_ready` of the non-granted port.
- A requester may drop `i_req_valid` before acceptance; nothing is recorded.
- Fairness: after port N is served, the other port wins the next tie, so two continuously requesting ports alternate 0,1,0,1.

## Timing
- Reset values:
  - state=IDLE, `prio`=0, `grant_id`=0, `addr_q`=0, buffer=0.
  - All outputs 0: `o_req_ready`, `o_resp_valid`, `o_mem_addr_valid`, `o_mem_data_ready`, `o_mem_addr`, `o_resp_data`.
- Reset is asynchronous: asserting it mid-transaction returns to IDLE immediately and discards any in-flight line. The memory model must tolerate an abandoned read.
- Minimum latency, with memory address-ready and data-valid both immediate:
  - Accept in cycle 0.
  - `o_mem_addr_valid` in cycle 1.
  - `o_mem_data_ready` in cycle 2.
  - `o_resp_valid` in cycle 3.
  - Back to IDLE in cycle 4 if `i_resp_ready`=1.
- Throughput: at most one line per 4 cycles. No request is accepted while a transaction is in flight.
- Valid outputs never drop before their handshake completes. Data and address are stable while valid is high.
- Simultaneous valid on both ports in the same IDLE cycle: `prio` decides; the loser keeps valid and is served next.

## Structure
- Shared package `kv_pkg`:
  - FSM state enum `kv_arb_state_t` (IDLE, ISSUE, WAIT_DATA, RESPOND).
  - Port-index constants `KV_PORT_ICACHE`=0, `KV_PORT_DCACHE`=1.
  - Line type `kv_line_t` (`LINE_SIZE × DATA_WIDTH`).
- One natural sub-module: `kv_rr_arbiter2`, a combinational 2-way round-robin pick from valid bits and `prio`. The FSM and buffer stay in the top.

## Test plan
- Single I-cache request: `i_req_addr[0]`=32'h1111_1000, memory returns {1,2,3,4} → `o_mem_addr`=32'h1111_1000; `o_resp_valid[0]` with data {1,2,3,4} in cycle 3; `o_resp_valid[1]` stays 0.
- Simultaneous requests after reset: port 0 addr 32'h0000_0040, port 1 addr 32'h0000_0080 → port 0 served first; then port 1 with 32'h0000_0080; then a second simultaneous pair serves port 0 again (alternation).
- Memory backpressure: `i_mem_addr_ready` low 5 cycles, then `i_mem_data_valid` delayed 7 cycles → address held stable throughout; no extra accept; response data matches memory exactly.
- Requester backpressure: `i_resp_ready[1]`=0 for 6 cycles → `o_resp_valid[1]` and data held stable; a port-0 request pending meanwhile is not accepted until return to IDLE.
- Reset mid-transaction: `i_rst` pulsed during WAIT_DATA → all outputs 0 asynchronously; the next request after release completes normally with fresh data.
- Spurious input: `i_mem_data_valid`=1 in IDLE and `i_resp_ready[0]`=1 with no response pending → no state change, no outputs asserted.
